// File: rtl/alu_iterative_pkg.sv
// Shared types and encodings for the iterative integer execute unit
// (base ALU plus M-extension multiply/divide).
package alu_iterative_pkg;

  typedef enum logic [4:0] {
    ALU_FUNC_ADD,
    ALU_FUNC_SUB,
    ALU_FUNC_SLL,
    ALU_FUNC_SLT,
    ALU_FUNC_SLTU,
    ALU_FUNC_XOR,
    ALU_FUNC_SRL,
    ALU_FUNC_SRA,
    ALU_FUNC_OR,
    ALU_FUNC_AND,
    ALU_FUNC_SEQ,
    ALU_FUNC_MUL,
    ALU_FUNC_MULH,
    ALU_FUNC_MULHSU,
    ALU_FUNC_MULHU,
    ALU_FUNC_DIV,
    ALU_FUNC_DIVU,
    ALU_FUNC_REM,
    ALU_FUNC_REMU
  } alu_func_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } alu_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  function automatic logic is_mul(input alu_func_t f);
    return (f == ALU_FUNC_MUL) || (f == ALU_FUNC_MULH) ||
           (f == ALU_FUNC_MULHSU) || (f == ALU_FUNC_MULHU);
  endfunction

  function automatic logic is_div(input alu_func_t f);
    return (f == ALU_FUNC_DIV) || (f == ALU_FUNC_DIVU) ||
           (f == ALU_FUNC_REM) || (f == ALU_FUNC_REMU);
  endfunction

endpackage

// File: rtl/alu_iterative_decode_alu_m.sv
// Combinational decode of opcode/funct3/funct7 into an ALU function and an
// illegal flag; MULDIV encodings are only recognised when ENABLE_M != 0.
module decode_alu_m
  import alu_iterative_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_func_t  func_o,
  output logic       illegal_o
);

  logic [6:0] f7_shift;

  always_comb begin
    func_o    = ALU_FUNC_ADD;
    illegal_o = 1'b0;
    // On RV64 the low funct7 bit of an immediate shift is shamt[5].
    f7_shift  = (XLEN == 64) ? {funct7_i[6:1], 1'b0} : funct7_i;

    case (opcode_i)
      OPC_OP: begin
        if (funct7_i == FUNCT7_BASE) begin
          case (funct3_i)
            3'b000:  func_o = ALU_FUNC_ADD;
            3'b001:  func_o = ALU_FUNC_SLL;
            3'b010:  func_o = ALU_FUNC_SLT;
            3'b011:  func_o = ALU_FUNC_SLTU;
            3'b100:  func_o = ALU_FUNC_XOR;
            3'b101:  func_o = ALU_FUNC_SRL;
            3'b110:  func_o = ALU_FUNC_OR;
            default: func_o = ALU_FUNC_AND;
          endcase
        end else if (funct7_i == FUNCT7_ALT) begin
          case (funct3_i)
            3'b000:  func_o = ALU_FUNC_SUB;
            3'b101:  func_o = ALU_FUNC_SRA;
            default: illegal_o = 1'b1;
          endcase
        end else if ((funct7_i == FUNCT7_MULDIV) && (ENABLE_M != 0)) begin
          case (funct3_i)
            FUNCT3_MUL:    func_o = ALU_FUNC_MUL;
            FUNCT3_MULH:   func_o = ALU_FUNC_MULH;
            FUNCT3_MULHSU: func_o = ALU_FUNC_MULHSU;
            FUNCT3_MULHU:  func_o = ALU_FUNC_MULHU;
            FUNCT3_DIV:    func_o = ALU_FUNC_DIV;
            FUNCT3_DIVU:   func_o = ALU_FUNC_DIVU;
            FUNCT3_REM:    func_o = ALU_FUNC_REM;
            default:       func_o = ALU_FUNC_REMU;
          endcase
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        case (funct3_i)
          3'b000: func_o = ALU_FUNC_ADD;
          3'b010: func_o = ALU_FUNC_SLT;
          3'b011: func_o = ALU_FUNC_SLTU;
          3'b100: func_o = ALU_FUNC_XOR;
          3'b110: func_o = ALU_FUNC_OR;
          3'b111: func_o = ALU_FUNC_AND;
          3'b001: begin
            if (f7_shift == FUNCT7_BASE) func_o = ALU_FUNC_SLL;
            else                         illegal_o = 1'b1;
          end
          default: begin
            if (f7_shift == FUNCT7_BASE)     func_o = ALU_FUNC_SRL;
            else if (f7_shift == FUNCT7_ALT) func_o = ALU_FUNC_SRA;
            else                             illegal_o = 1'b1;
          end
        endcase
      end
      OPC_BRANCH: begin
        case (funct3_i)
          3'b000, 3'b001: func_o = ALU_FUNC_SEQ;
          3'b100, 3'b101: func_o = ALU_FUNC_SLT;
          3'b110, 3'b111: func_o = ALU_FUNC_SLTU;
          default:        illegal_o = 1'b1;
        endcase
      end
      OPC_JALR: begin
        if (funct3_i == 3'b000) func_o = ALU_FUNC_ADD;
        else                    illegal_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_iterative.sv
// Handshaked execute unit: single-cycle base ALU ops, XLEN-cycle shift-add
// multiply and XLEN-cycle restoring divide, one operation in flight.
module alu_iterative
  import alu_iterative_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int SHW   = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  alu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;
  // acc holds {hi, lo} of the product, or {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  alu_func_t         func_q, func_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;

  alu_func_t         dec_func;
  logic              dec_illegal;
  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   mag_a, mag_b;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_fin;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_quo, div_rem;

  decode_alu_m #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .func_o    (dec_func),
    .illegal_o (dec_illegal)
  );

  function automatic logic [XLEN-1:0] alu_basic(input alu_func_t f,
                                                input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y);
    logic [SHW-1:0] sh;
    sh = y[SHW-1:0];
    case (f)
      ALU_FUNC_ADD:  return x + y;
      ALU_FUNC_SUB:  return x - y;
      ALU_FUNC_SLL:  return x << sh;
      ALU_FUNC_SLT:  return {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      ALU_FUNC_SLTU: return {{(XLEN-1){1'b0}}, (x < y)};
      ALU_FUNC_XOR:  return x ^ y;
      ALU_FUNC_SRL:  return x >> sh;
      ALU_FUNC_SRA:  return $unsigned($signed(x) >>> sh);
      ALU_FUNC_OR:   return x | y;
      ALU_FUNC_AND:  return x & y;
      ALU_FUNC_SEQ:  return {{(XLEN-1){1'b0}}, (x == y)};
      default:       return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  always_comb begin
    a_sgn = (dec_func == ALU_FUNC_MUL) || (dec_func == ALU_FUNC_MULH) ||
            (dec_func == ALU_FUNC_MULHSU) || (dec_func == ALU_FUNC_DIV) ||
            (dec_func == ALU_FUNC_REM);
    b_sgn = (dec_func == ALU_FUNC_MUL) || (dec_func == ALU_FUNC_MULH) ||
            (dec_func == ALU_FUNC_DIV) || (dec_func == ALU_FUNC_REM);
    mag_a = magnitude(a, a_sgn);
    mag_b = magnitude(b, b_sgn);
  end

  // One shift-add / one restoring-subtract step per cycle.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    mul_fin   = neg_q ? -mul_next : mul_next;
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    div_quo   = neg_q  ? -div_next[XLEN-1:0]      : div_next[XLEN-1:0];
    div_rem   = rneg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    func_d    = func_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          func_d    = dec_func;
          illegal_d = dec_illegal;
          state_d   = DONE;
          if (dec_illegal) begin
            result_d = '0;
          end else if (is_mul(dec_func)) begin
            acc_d   = {{XLEN{1'b0}}, mag_b};
            opd_d   = mag_a;
            neg_d   = (a_sgn & a[XLEN-1]) ^ (b_sgn & b[XLEN-1]);
            cnt_d   = CNT_W'(XLEN);
            state_d = MUL;
          end else if (is_div(dec_func)) begin
            if (b == '0) begin
              result_d = ((dec_func == ALU_FUNC_DIV) || (dec_func == ALU_FUNC_DIVU)) ? ONES : a;
            end else if (a_sgn && (a == XMIN) && (b == ONES)) begin
              result_d = (dec_func == ALU_FUNC_DIV) ? XMIN : '0;
            end else begin
              acc_d   = {{XLEN{1'b0}}, mag_a};
              opd_d   = mag_b;
              neg_d   = a_sgn & (a[XLEN-1] ^ b[XLEN-1]);
              rneg_d  = a_sgn & a[XLEN-1];
              cnt_d   = CNT_W'(XLEN);
              state_d = DIV;
            end
          end else begin
            result_d = alu_basic(dec_func, a, b);
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = (func_q == ALU_FUNC_MUL) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
          state_d  = DONE;
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = ((func_q == ALU_FUNC_DIV) || (func_q == ALU_FUNC_DIVU)) ? div_quo : div_rem;
          state_d  = DONE;
        end
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    opd_q  <= opd_d;
    func_q <= func_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed, table-driven bench for alu_iterative (XLEN=32), with a second
// instance built without the M extension.
module tb_alu_iterative;

  localparam int XLEN = 32;
  localparam logic [6:0] OP = 7'h33, OPI = 7'h13, BR = 7'h63, JALR = 7'h67;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, out_ready;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a, b;
  logic            in_ready, out_valid, illegal;
  logic [XLEN-1:0] result;
  logic            nom_in_ready, nom_out_valid, nom_illegal;
  logic [XLEN-1:0] nom_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_iterative #(.XLEN(XLEN), .ENABLE_M(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
  );

  alu_iterative #(.XLEN(XLEN), .ENABLE_M(0)) dut_nom (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nom_in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .a(a), .b(b),
    .out_valid(nom_out_valid), .out_ready(out_ready), .result(nom_result),
    .illegal(nom_illegal)
  );

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic       ill;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] res, input logic ill, input int lat);
    vec_t v;
    v.name = name; v.opc = opc; v.f3 = f3; v.f7 = f7; v.a = va; v.b = vb;
    v.res = res; v.ill = ill; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic drive_accept(input logic [6:0] opc, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] va, input logic [31:0] vb);
    opcode = opc; funct3 = f3; funct7 = f7; a = va; b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input logic chk_nom);
    int lat;
    @(negedge clk);
    check({v.name, " in_ready"}, in_ready, 1);
    drive_accept(v.opc, v.f3, v.f7, v.a, v.b);
    if (chk_nom) begin
      check({v.name, " nom_result"}, nom_result, v.res);
      check({v.name, " nom_illegal"}, nom_illegal, v.ill);
    end
    wait_valid(lat);
    check({v.name, " latency"}, lat, v.lat);
    check({v.name, " result"}, result, v.res);
    check({v.name, " illegal"}, illegal, v.ill);
    @(negedge clk);
    check({v.name, " in_ready_after"}, in_ready, 1);
    check({v.name, " out_valid_after"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vec_t v;

    add_vec("add",       OP,   3'd0, 7'h00, 32'd5,        32'd7,        32'd12,       1'b0, 1);
    add_vec("sub",       OP,   3'd0, 7'h20, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1);
    add_vec("addi",      OPI,  3'd0, 7'h00, 32'd10,       32'hFFFFFFFF, 32'd9,        1'b0, 1);
    add_vec("slt",       OP,   3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
    add_vec("sltu",      OP,   3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
    add_vec("xor",       OP,   3'd4, 7'h00, 32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0, 1);
    add_vec("or",        OP,   3'd6, 7'h00, 32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0, 1);
    add_vec("and",       OP,   3'd7, 7'h00, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1);
    add_vec("sll",       OP,   3'd1, 7'h00, 32'd1,        32'h24,       32'h10,       1'b0, 1);
    add_vec("srli",      OPI,  3'd5, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1);
    add_vec("srai",      OPI,  3'd5, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1);
    add_vec("beq",       BR,   3'd0, 7'h00, 32'd3,        32'd3,        32'd1,        1'b0, 1);
    add_vec("bne",       BR,   3'd1, 7'h00, 32'd3,        32'd4,        32'd0,        1'b0, 1);
    add_vec("blt",       BR,   3'd4, 7'h00, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 1);
    add_vec("bltu",      BR,   3'd6, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1);
    add_vec("br_f3_010", BR,   3'd2, 7'h00, 32'd1,        32'd2,        32'd0,        1'b1, 1);
    add_vec("jalr",      JALR, 3'd0, 7'h00, 32'h100,      32'd4,        32'h104,      1'b0, 1);
    add_vec("opc_7f",    7'h7F,3'd0, 7'h00, 32'd5,        32'd7,        32'd0,        1'b1, 1);
    add_vec("op_bad_f7", OP,   3'd1, 7'h20, 32'd5,        32'd7,        32'd0,        1'b1, 1);
    add_vec("mul",       OP,   3'd0, 7'h01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 1'b0, 33);
    add_vec("mulh",      OP,   3'd1, 7'h01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 1'b0, 33);
    add_vec("mulhsu",    OP,   3'd2, 7'h01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 1'b0, 33);
    add_vec("mulhu",     OP,   3'd3, 7'h01, 32'hFFFFFFFD, 32'd7,        32'd6,        1'b0, 33);
    add_vec("mulhu_max", OP,   3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
    add_vec("mulh_m1",   OP,   3'd1, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0, 33);
    add_vec("div",       OP,   3'd4, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33);
    add_vec("rem",       OP,   3'd6, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33);
    add_vec("div_negb",  OP,   3'd4, 7'h01, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    add_vec("rem_negb",  OP,   3'd6, 7'h01, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 33);
    add_vec("divu",      OP,   3'd5, 7'h01, 32'd100,      32'd7,        32'd14,       1'b0, 33);
    add_vec("remu",      OP,   3'd7, 7'h01, 32'd100,      32'd7,        32'd2,        1'b0, 33);
    add_vec("divu_by0",  OP,   3'd5, 7'h01, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, 1);
    add_vec("remu_by0",  OP,   3'd7, 7'h01, 32'd7,        32'd0,        32'd7,        1'b0, 1);
    add_vec("div_by0",   OP,   3'd4, 7'h01, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b0, 1);
    add_vec("rem_by0",   OP,   3'd6, 7'h01, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b0, 1);
    add_vec("div_ovf",   OP,   3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    add_vec("rem_ovf",   OP,   3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset illegal", illegal, 0);

    foreach (vecs[i]) begin
      v = vecs[i];
      run_vec(v, !((v.opc == OP) && (v.f7 == 7'h01)));
    end

    // M encoding on the instance without the M extension
    @(negedge clk);
    drive_accept(OP, 3'd0, 7'h01, 32'd3, 32'd5);
    check("nom_mul out_valid", nom_out_valid, 1);
    check("nom_mul illegal", nom_illegal, 1);
    check("nom_mul result", nom_result, 0);
    wait_valid(lat);
    check("mul_3x5 result", result, 15);
    @(negedge clk);

    // Backpressure after a divide completes
    out_ready = 1'b0;
    @(negedge clk);
    drive_accept(OP, 3'd4, 7'h01, 32'd100, 32'd7);
    wait_valid(lat);
    check("bp latency", lat, 33);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp out_valid", out_valid, 1);
      check("bp result", result, 14);
      check("bp illegal", illegal, 0);
      check("bp in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp released out_valid", out_valid, 0);
    check("bp released in_ready", in_ready, 1);

    // Reset in the middle of a multiply
    @(negedge clk);
    drive_accept(OP, 3'd0, 7'h01, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    check("mid_mul busy", in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_mul reset out_valid", out_valid, 0);
    check("mid_mul reset in_ready", in_ready, 1);
    check("mid_mul reset result", result, 0);
    v.name = "add_after_reset"; v.opc = OP; v.f3 = 3'd0; v.f7 = 7'h00;
    v.a = 32'd20; v.b = 32'd22; v.res = 32'd42; v.ill = 1'b0; v.lat = 1;
    run_vec(v, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
